// File: rtl/calc_b_vector_pkg.sv
// Shared types/constants for calc_b_vector (b = Q^T * y).
// CALC_B_SATURATE_EN: saturate b[k] to 24 bits instead of wrapping.
package calc_b_pkg;

    localparam int DATA_W   = 24;
    localparam int FRAC     = 13;
    localparam int LANES    = 4;
    localparam int ROWS_MAX = 8;
    localparam int COLS_MAX = 16;
    localparam int ACC_W    = 56;
    localparam int PROD_W   = 2 * DATA_W;
    localparam int SUM_W    = PROD_W + 2;
    localparam int WORD_W   = DATA_W * LANES;
    localparam int YA_W     = $clog2(ROWS_MAX);
    localparam int IDX_W    = $clog2(COLS_MAX);
    localparam int QA_W     = IDX_W + YA_W;
    localparam int K_W      = IDX_W + 1;

    localparam logic signed [ACC_W-1:0] B_MAX =
        ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] B_MIN = -B_MAX - 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        MAC,
        WRITE,
        DONE
    } state_t;

    function automatic logic [DATA_W-1:0] fit_b(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC;
`ifdef CALC_B_SATURATE_EN
        if (s > B_MAX)
            return B_MAX[DATA_W-1:0];
        else if (s < B_MIN)
            return B_MIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
`else
        return s[DATA_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/calc_b_vector_if.sv
// Control, BRAM read and b-store write signals of calc_b_vector.
// master = controller/memories side, slave = calc_b_vector.
interface calc_b_vector_if;
    import calc_b_pkg::*;

    logic              start_calc_b;
    logic [K_W-1:0]    K_final;
    logic [YA_W-1:0]   M_limit;
    logic [QA_W-1:0]   q_addr;
    logic [WORD_W-1:0] q_rdata;
    logic [YA_W-1:0]   y_addr;
    logic [WORD_W-1:0] y_data;
    logic [IDX_W-1:0]  b_idx;
    logic [DATA_W-1:0] b_val;
    logic              b_we;
    logic              done_b_vec;

    modport master (
        output start_calc_b, K_final, M_limit,
        output q_rdata, y_data,
        input  q_addr, y_addr,
        input  b_idx, b_val, b_we, done_b_vec
    );

    modport slave (
        input  start_calc_b, K_final, M_limit,
        input  q_rdata, y_data,
        output q_addr, y_addr,
        output b_idx, b_val, b_we, done_b_vec
    );

endinterface

// File: rtl/calc_b_vector_dot4_q.sv
// dot4_q: 4-lane signed Q10.13 multiply and adder tree.
// Full-precision 48-bit products, 50-bit sum, no rounding.
module dot4_q
    import calc_b_pkg::*;
(
    input  logic [WORD_W-1:0]       i_q,
    input  logic [WORD_W-1:0]       i_y,
    output logic signed [SUM_W-1:0] o_sum
);

    logic signed [PROD_W-1:0] w_p [LANES];
    logic signed [PROD_W:0]   w_s01;
    logic signed [PROD_W:0]   w_s23;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_p[i] = $signed(i_q[DATA_W*i +: DATA_W])
                   * $signed(i_y[DATA_W*i +: DATA_W]);
        end
    end

    assign w_s01 = (PROD_W+1)'(w_p[0]) + (PROD_W+1)'(w_p[1]);
    assign w_s23 = (PROD_W+1)'(w_p[2]) + (PROD_W+1)'(w_p[3]);
    assign o_sum = SUM_W'(w_s01) + SUM_W'(w_s23);

endmodule

// File: rtl/calc_b_vector.sv
// calc_b_vector: b[k] = sum_r dot4(Q[k][r], y[r]), one b_we per column.
// CALC_B_SATURATE_EN selects saturating (else wrapping) 24-bit b_val.
module calc_b_vector
    import calc_b_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    calc_b_vector_if.slave bus
);

    state_t r_state;
    state_t w_next;

    logic [K_W-1:0]          r_kcnt;
    logic [K_W-1:0]          r_k;
    logic [YA_W-1:0]         r_m;
    logic [YA_W-1:0]         r_r;
    logic signed [ACC_W-1:0] r_acc;
    logic [QA_W-1:0]         r_q_addr;
    logic [YA_W-1:0]         r_y_addr;
    logic [IDX_W-1:0]        r_b_idx;
    logic [DATA_W-1:0]       r_b_val;
    logic                    r_b_we;
    logic                    r_done;

    logic                    w_load;
    logic                    w_issue;
    logic                    w_mac;
    logic                    w_write;
    logic                    w_fin;
    logic                    w_last_row;
    logic                    w_last_col;
    logic [K_W-1:0]          w_kclamp;
    logic signed [SUM_W-1:0] w_dot;

    dot4_q u_dot4 (
        .i_q   (bus.q_rdata),
        .i_y   (bus.y_data),
        .o_sum (w_dot)
    );

    assign w_kclamp   = (bus.K_final > K_W'(COLS_MAX))
                      ? K_W'(COLS_MAX) : bus.K_final;
    assign w_last_row = (r_r == r_m);
    assign w_last_col = (r_k == r_kcnt - K_W'(1));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start_calc_b)
                    w_next = (bus.K_final == '0) ? DONE : ADDR;
            end
            ADDR:  w_next = WAIT;
            WAIT:  w_next = MAC;
            MAC:   w_next = w_last_row ? WRITE : ADDR;
            WRITE: w_next = w_last_col ? DONE : ADDR;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load  = (r_state == IDLE) && bus.start_calc_b;
        w_issue = (r_state == ADDR);
        w_mac   = (r_state == MAC);
        w_write = (r_state == WRITE);
        w_fin   = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kcnt   <= '0;
            r_k      <= '0;
            r_m      <= '0;
            r_r      <= '0;
            r_acc    <= '0;
            r_q_addr <= '0;
            r_y_addr <= '0;
            r_b_idx  <= '0;
            r_b_val  <= '0;
            r_b_we   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_b_we <= w_write;
            r_done <= w_fin;
            if (w_load) begin
                r_kcnt <= w_kclamp;
                r_m    <= bus.M_limit;
                r_k    <= '0;
                r_r    <= '0;
                r_acc  <= '0;
            end
            if (w_issue) begin
                r_q_addr <= {r_k[IDX_W-1:0], r_r};
                r_y_addr <= r_r;
            end
            if (w_mac) begin
                r_acc <= r_acc + ACC_W'(w_dot);
                if (!w_last_row)
                    r_r <= r_r + YA_W'(1);
            end
            // Column finished: publish, then clear for the next column
            if (w_write) begin
                r_b_val <= fit_b(r_acc);
                r_b_idx <= r_k[IDX_W-1:0];
                r_acc   <= '0;
                r_r     <= '0;
                if (!w_last_col)
                    r_k <= r_k + K_W'(1);
            end
        end
    end

    assign bus.q_addr     = r_q_addr;
    assign bus.y_addr     = r_y_addr;
    assign bus.b_idx      = r_b_idx;
    assign bus.b_val      = r_b_val;
    assign bus.b_we       = r_b_we;
    assign bus.done_b_vec = r_done;

endmodule

// File: tb/tb_calc_b_vector.sv
// Scoreboard bench for calc_b_vector with 1-cycle BRAM models.
// Honours CALC_B_SATURATE_EN in its reference model.
module tb_calc_b_vector;

    logic clk;
    logic rst;

    calc_b_vector_if bus();

    calc_b_vector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [95:0] qmem [128];
    logic [95:0] ymem [8];

    always @(posedge clk) begin
        bus.q_rdata <= qmem[bus.q_addr];
        bus.y_data  <= ymem[bus.y_addr];
    end

    int total;
    int bad;
    int cyc;
    int t_start;
    int t_first;
    bit first_seen;
    logic [27:0] exp_q [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint lane(input logic [95:0] w, input int i);
        logic [23:0] v;
        v = w[24*i +: 24];
        return longint'($signed(v));
    endfunction

    function automatic logic [23:0] model_b(input int k, input int m);
        longint acc;
        longint s;
        acc = 0;
        for (int r = 0; r <= m; r++)
            for (int i = 0; i < 4; i++)
                acc += lane(qmem[k*8+r], i) * lane(ymem[r], i);
        s = acc >>> 13;
`ifdef CALC_B_SATURATE_EN
        if (s > 64'sd8388607) s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
`endif
        return s[23:0];
    endfunction

    always @(negedge clk) begin
        logic [27:0] e;
        if (!rst && bus.b_we === 1'b1) begin
            if (!first_seen) begin
                first_seen = 1'b1;
                t_first = cyc;
            end
            if (exp_q.size() == 0) begin
                chk("b_extra", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("b_idx", 64'(bus.b_idx), 64'(e[27:24]));
                chk("b_val", 64'(bus.b_val), 64'(e[23:0]));
            end
        end
    end

    task automatic fill_col(input int k, input logic [23:0] v);
        for (int r = 0; r < 8; r++) qmem[k*8+r] = {4{v}};
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 128; a++)
            qmem[a] = {$urandom, $urandom, $urandom};
        for (int r = 0; r < 8; r++)
            ymem[r] = {$urandom, $urandom, $urandom};
    endtask

    task automatic run(input int kf, input int m, input bit busy);
        int kk;
        int per;
        bit got;
        kk = (kf > 16) ? 16 : kf;
        per = 3 * (m + 1) + 1;
        for (int k = 0; k < kk; k++)
            exp_q.push_back({4'(k), model_b(k, m)});
        first_seen = 1'b0;
        got = 1'b0;
        @(negedge clk);
        bus.start_calc_b = 1'b1;
        bus.K_final = 5'(kf);
        bus.M_limit = 3'(m);
        t_start = cyc + 1;
        @(negedge clk);
        bus.start_calc_b = 1'b0;
        bus.K_final = 5'($urandom_range(0, 31));
        bus.M_limit = 3'($urandom_range(0, 7));
        if (busy) begin
            @(negedge clk);
            bus.start_calc_b = 1'b1;
            bus.K_final = 5'd1;
            @(negedge clk);
            bus.start_calc_b = 1'b0;
        end
        for (int i = 0; i < 2000 && !got; i++) begin
            if (bus.done_b_vec === 1'b1) begin
                got = 1'b1;
                chk("done_t", 64'(cyc - t_start), 64'(kk*per + 1));
            end else begin
                @(negedge clk);
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse", 64'(bus.done_b_vec), 0);
        chk("left", 64'(exp_q.size()), 0);
        if (kk > 0)
            chk("first_lat", 64'(t_first - t_start), 64'(per));
        else
            chk("no_we", 64'(first_seen), 0);
        exp_q.delete();
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        t_start = 0;
        t_first = 0;
        first_seen = 1'b0;
        rst = 1'b1;
        bus.start_calc_b = 1'b0;
        bus.K_final = '0;
        bus.M_limit = '0;
        for (int a = 0; a < 128; a++) qmem[a] = '0;
        for (int r = 0; r < 8; r++) ymem[r] = '0;
        repeat (3) @(negedge clk);
        chk("rst_q_addr", 64'(bus.q_addr), 0);
        chk("rst_y_addr", 64'(bus.y_addr), 0);
        chk("rst_b_idx", 64'(bus.b_idx), 0);
        chk("rst_b_val", 64'(bus.b_val), 0);
        chk("rst_b_we", 64'(bus.b_we), 0);
        chk("rst_done", 64'(bus.done_b_vec), 0);
        rst = 1'b0;
        @(negedge clk);

        fill_col(0, 24'h002000);
        fill_col(1, 24'h001000);
        for (int r = 0; r < 8; r++) ymem[r] = {4{24'h002000}};
        run(2, 7, 1'b0);

        qmem[0] = {24'h001000, 24'h004000, 24'hFFE000, 24'h002000};
        run(1, 0, 1'b0);

        run(0, 3, 1'b0);

        fill_col(0, 24'hFFE000);
        run(1, 7, 1'b0);

        fill_col(0, 24'h7FFFFF);
        for (int r = 0; r < 8; r++) ymem[r] = {4{24'h7FFFFF}};
        run(1, 7, 1'b0);

        fill_rand();
        run(20, 3, 1'b1);
        run(5, 2, 1'b0);

        @(negedge clk);
        bus.start_calc_b = 1'b1;
        bus.K_final = 5'd3;
        bus.M_limit = 3'd7;
        @(negedge clk);
        bus.start_calc_b = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_we", 64'(bus.b_we), 0);
        chk("mid_rst_val", 64'(bus.b_val), 0);
        chk("mid_rst_qa", 64'(bus.q_addr), 0);
        first_seen = 1'b0;
        begin
            int dseen;
            dseen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.done_b_vec === 1'b1) dseen++;
            end
            chk("mid_rst_idle", 64'(dseen + int'(first_seen)), 0);
        end
        fill_rand();
        run(3, 5, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
